// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF-to-ID instruction queue: circular buffer of {pc, inst} with flush.
// Optional IFQ_BYPASS_EN: an empty queue forwards if_* straight to id_*.
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         if_valid,
   input  logic [ADDR_W-1:0]            if_pc,
   input  logic [DATA_W-1:0]            if_inst,
   output logic                         if_ready,
   input  logic                         id_stall,
   output logic                         id_valid,
   output logic [ADDR_W-1:0]            id_pc,
   output logic [DATA_W-1:0]            id_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [DATA_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              q_valid;
   logic              push;
   logic              pop;

   assign q_valid  = (count != '0);
   // Full-ness is purely registered state, so if_ready never depends on id_stall or if_valid.
   assign if_ready = (count < FULL_CNT);
   assign pop      = q_valid && !id_stall && !flush;

`ifdef IFQ_BYPASS_EN
   logic byp_hit;
   logic byp_take;

   assign byp_hit  = !q_valid && if_valid;
   // A bypassed instruction that ID takes right away is never written into the buffer.
   assign byp_take = byp_hit && !id_stall && !flush;
   assign push     = if_valid && if_ready && !flush && !byp_take;

   always_comb begin
      id_valid = q_valid || byp_hit;
      id_pc    = '0;
      id_inst  = '0;
      if (q_valid) begin
         id_pc   = pc_mem[rd_ptr];
         id_inst = inst_mem[rd_ptr];
      end else if (byp_hit) begin
         id_pc   = if_pc;
         id_inst = if_inst;
      end
   end
`else
   assign push = if_valid && if_ready && !flush;

   always_comb begin
      id_valid = q_valid;
      id_pc    = '0;
      id_inst  = '0;
      if (q_valid) begin
         id_pc   = pc_mem[rd_ptr];
         id_inst = inst_mem[rd_ptr];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         pc_mem[wr_ptr]   <= if_pc;
         inst_mem[wr_ptr] <= if_inst;
      end
   end

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue (DEPTH=4); IFQ_BYPASS_EN adds bypass vectors.
module tb_if_id_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic        id_stall;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_en   = 1'b0;

   if_id_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_ready (if_ready),
      .id_stall (id_stall),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .count    (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after a rising edge and are applied on the next one.
   task automatic cyc(input logic v, input logic [31:0] pc, input logic st,
                      input logic fl, input logic acc);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst_of(pc);
      id_stall = st;
      flush    = fl;
      if (acc) exp_q.push_back('{pc, inst_of(pc)});
      @(posedge clk);
      #1;
   endtask

   // Monitor: every consumption by ID must match the scoreboard head; idle output must be a NOP bubble.
   always @(negedge clk) begin
      if (mon_en && rst_n && !flush) begin
         if (id_valid && !id_stall) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop: got pc 0x%0h expected no entry at %0t", id_pc, $time);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               check("pop_pc", id_pc, e.pc);
               check("pop_inst", id_inst, e.inst);
            end
         end else if (!id_valid) begin
            check("bubble_pc", id_pc, 32'h0);
            check("bubble_inst", id_inst, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_inst", id_inst, 32'h0);
      check("rst_if_ready", 32'(if_ready), 32'd1);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Fill under stall, overflow push ignored, then drain in order.
      cyc(1, 32'h100, 1, 0, 1);
      check("lat_id_valid", 32'(id_valid), 32'd1);
      check("lat_id_pc", id_pc, 32'h100);
      check("lat_count", 32'(count), 32'd1);
      cyc(1, 32'h104, 1, 0, 1);
      cyc(1, 32'h108, 1, 0, 1);
      cyc(1, 32'h10C, 1, 0, 1);
      check("full_count", 32'(count), 32'd4);
      check("full_if_ready", 32'(if_ready), 32'd0);
      cyc(1, 32'h110, 1, 0, 0);
      check("ovf_count", 32'(count), 32'd4);
      check("stall_hold_pc", id_pc, 32'h100);
      repeat (4) cyc(0, 32'h0, 0, 0, 0);
      check("drain_id_valid", 32'(id_valid), 32'd0);
      check("drain_id_pc", id_pc, 32'h0);
      check("drain_count", 32'(count), 32'd0);

      // Streaming push+pop at count 1 wraps pointers several times.
      cyc(1, 32'h400, 1, 0, 1);
      for (int i = 1; i <= 10; i++) begin
         cyc(1, 32'h400 + 32'(4 * i), 0, 0, 1);
         check("stream_count", 32'(count), 32'd1);
      end
      cyc(0, 32'h0, 0, 0, 0);
      check("stream_end_count", 32'(count), 32'd0);

      // Flush at count 3 with a same-cycle push.
      cyc(1, 32'h500, 1, 0, 1);
      cyc(1, 32'h504, 1, 0, 1);
      cyc(1, 32'h508, 1, 0, 1);
      check("pre_flush_count", 32'(count), 32'd3);
      cyc(1, 32'h50C, 0, 1, 0);
      exp_q.delete();
      check("flush_count", 32'(count), 32'd0);
      check("flush_id_valid", 32'(id_valid), 32'd0);
      check("flush_id_inst", id_inst, 32'h0);
      check("flush_if_ready", 32'(if_ready), 32'd1);
      cyc(0, 32'h0, 0, 0, 0);
      check("post_flush_valid", 32'(id_valid), 32'd0);

      // Push+pop at count DEPTH-1.
      cyc(1, 32'h700, 1, 0, 1);
      cyc(1, 32'h704, 1, 0, 1);
      cyc(1, 32'h708, 1, 0, 1);
      cyc(1, 32'h70C, 0, 0, 1);
      check("d1_count", 32'(count), 32'd3);
      check("d1_head_pc", id_pc, 32'h704);
      repeat (3) cyc(0, 32'h0, 0, 0, 0);
      check("d1_drain_count", 32'(count), 32'd0);

      // Reset mid-stream at count 2.
      cyc(1, 32'h600, 1, 0, 1);
      cyc(1, 32'h604, 1, 0, 1);
      check("pre_rst_count", 32'(count), 32'd2);
      rst_n = 1'b0;
      cyc(1, 32'h608, 0, 0, 0);
      rst_n = 1'b1;
      exp_q.delete();
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_id_valid", 32'(id_valid), 32'd0);
      check("mid_rst_if_ready", 32'(if_ready), 32'd1);
      cyc(1, 32'h200, 1, 0, 1);
      check("post_rst_valid", 32'(id_valid), 32'd1);
      check("post_rst_pc", id_pc, 32'h200);
      cyc(0, 32'h0, 0, 0, 0);
      check("post_rst_count", 32'(count), 32'd0);

`ifdef IFQ_BYPASS_EN
      // Empty queue, ID free: forwarded combinationally, never stored.
      if_valid = 1'b1; if_pc = 32'h300; if_inst = inst_of(32'h300); id_stall = 1'b0; flush = 1'b0;
      exp_q.push_back('{32'h300, inst_of(32'h300)});
      #1;
      check("byp_id_valid", 32'(id_valid), 32'd1);
      check("byp_id_pc", id_pc, 32'h300);
      check("byp_id_inst", id_inst, inst_of(32'h300));
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      check("byp_count", 32'(count), 32'd0);
      // Empty queue, ID stalled: shown combinationally and stored.
      if_valid = 1'b1; if_pc = 32'h300; if_inst = inst_of(32'h300); id_stall = 1'b1;
      exp_q.push_back('{32'h300, inst_of(32'h300)});
      #1;
      check("byp_st_valid", 32'(id_valid), 32'd1);
      check("byp_st_pc", id_pc, 32'h300);
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      check("byp_st_count", 32'(count), 32'd1);
      check("byp_st_pc_q", id_pc, 32'h300);
      cyc(0, 32'h0, 1, 0, 0);
      check("byp_st_hold", id_pc, 32'h300);
      cyc(0, 32'h0, 0, 0, 0);
      check("byp_end_count", 32'(count), 32'd0);
`endif

      cyc(0, 32'h0, 0, 0, 0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
